instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Parametrised fetch stage: captures multi-instruction ibus responses and trims them per start slot and predicted-taken branches.
//  Buffers surviving slots in a circular instruction queue; presents up to ISSUE_WIDTH in-order entries to decode per cycle.
//  Sits between pcfetch/ibus and decode; decouples ibus stalls from decode stalls; drops stale responses after flush.
// PARAMETERS
//  FETCH_WIDTH  2  instructions per ibus response (data width 32*FETCH_WIDTH), power of 2
//  ISSUE_WIDTH  2  max entries presented to / popped by decode per cycle, <= DEPTH
//  DEPTH        8  queue entries, power of 2, >= 2*FETCH_WIDTH
//  MAX_OUTST    4  max outstanding ibus requests tracked for flush drop
// PORTS
//  clk                 in   1              clock, rising edge
//  reset               in   1              asynchronous, active-low
//  flush               in   1              redirect: clear queue, drop in-flight responses
//  inst_ibus_req_fire  in   1              ibus request accepted this cycle
//  inst_ibus_data_ok   in   1              response valid this cycle
//  inst_ibus_data      in   32*FETCH_WIDTH slot i at bits [32i+31:32i]
//  inst_ibus_index     in   clog2(FW)      first valid slot of response
//  pc_line             in   32             PC of slot 0 of the response
//  tlb_ex_in           in   1              fetch TLB exception for this response
//  pred_taken          in   FETCH_WIDTH    per-slot predicted-taken
//  pred_target         in   32*FETCH_WIDTH per-slot predicted target
//  ibus_allow          out  1              pcfetch may issue a new request
//  out_en              out  ISSUE_WIDTH    valid entries at head, contiguous from bit 0
//  out_instr/out_pc    out  32*ISSUE_WIDTH instruction / PC per output slot
//  out_taken/out_target out 1/32 per slot  prediction carried with entry
//  out_exc_adel/out_exc_tlb out 1 per slot pc[1:0]!=0 / tlb_ex flag
//  deq_cnt             in   clog2(IW+1)    entries decode pops this cycle
// BEHAVIOUR
//  - Reset (async): queue empty, head=tail=0, count=0, ds_pending=0, drop_cnt=0, outst=0; out_en=0, ibus_allow=1; payload outputs 0.
//  - Slot i kept iff i>=index AND no earlier kept slot j<i-1 with pred_taken[j] (taken branch keeps its delay slot, drops rest).
//  - Taken at slot FW-1 kept: set ds_pending; next accepted response keeps only its first kept slot, then clears ds_pending.
//  - tlb_ex_in=1: enqueue only slot index, out_exc_tlb=1, instr=0, taken=0.
//  - Kept slots compacted, enqueued in slot order at tail; entry pc = pc_line + 4*i; exc_adel = pc_line[1:0]!=0.
//  - ibus_allow = (DEPTH - count - outst*FW) >= FW AND outst < MAX_OUTST; data_ok therefore never meets a full queue.
//  - outst: +1 on req_fire, -1 on data_ok; both same cycle -> unchanged.
//  - Flush: count/head/tail/ds_pending cleared next edge; drop_cnt <= outst minus data_ok that cycle (plus req_fire that cycle).
//  - data_ok with drop_cnt>0: response discarded, drop_cnt-1. data_ok in flush cycle: discarded.
//  - out_en[k]=1 iff k<count; slot k = entry head+k mod DEPTH. Pop deq_cnt next edge; deq_cnt>popcount(out_en) is illegal (assert).
//  - Enqueue and dequeue same cycle: count += kept - deq_cnt. Pointers wrap mod DEPTH.
//  - Latency: response -> out_en one cycle later (without bypass).
// CONFIGURATION
//  FETCHQ_BYPASS_EN defined: queue empty and no drop -> kept slots of current response drive out_* combinationally same cycle.
//   Popped entries not written; the remainder enqueued.
//  Not defined: out_* driven only from queue registers; min latency 1 cycle; no ibus-to-decode combinational path.
// TESTING
//  - Reset mid-traffic (count=5): reset low -> same cycle out_en=0, ibus_allow=1; after release count=0.
//  - data_ok, index=1, pc_line=0x8000_0000 -> one entry pc 0x8000_0004; out_en=2'b01 next cycle.
//  - FW=2, pred_taken=2'b01 -> both slots kept, no ds_pending. pred_taken=2'b10 -> ds_pending.
//    Next response keeps only slot 0.
//  - Fill to 8 with deq_cnt=0: ibus_allow=0 at count>=7 (or outst>0 pushing free<2); no entry lost.
//    deq_cnt=2 reasserts allow.
//  - 2 outstanding, flush -> both later responses discarded (out_en stays 0); third, post-flush response enqueued.
//  - tlb_ex_in=1, index=0 -> single entry out_exc_tlb=1, instr=0.
//    With FETCHQ_BYPASS_EN and empty queue: out_en[0]=1 same cycle.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: trims multi-slot ibus responses and queues them for decode.
// Define FETCHQ_BYPASS_EN to forward a response to decode while the queue is empty.
module instr_fetch_queue #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8,
  parameter int MAX_OUTST   = 4,
  localparam int IDXW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int DQW  = $clog2(ISSUE_WIDTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      inst_ibus_req_fire,
  input  logic                      inst_ibus_data_ok,
  input  logic [32*FETCH_WIDTH-1:0] inst_ibus_data,
  input  logic [IDXW-1:0]           inst_ibus_index,
  input  logic [31:0]               pc_line,
  input  logic                      tlb_ex_in,
  input  logic [FETCH_WIDTH-1:0]    pred_taken,
  input  logic [32*FETCH_WIDTH-1:0] pred_target,
  output logic                      ibus_allow,
  output logic [ISSUE_WIDTH-1:0]    out_en,
  output logic [32*ISSUE_WIDTH-1:0] out_instr,
  output logic [32*ISSUE_WIDTH-1:0] out_pc,
  output logic [ISSUE_WIDTH-1:0]    out_taken,
  output logic [32*ISSUE_WIDTH-1:0] out_target,
  output logic [ISSUE_WIDTH-1:0]    out_exc_adel,
  output logic [ISSUE_WIDTH-1:0]    out_exc_tlb,
  input  logic [DQW-1:0]            deq_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int KW = $clog2(FETCH_WIDTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        adel;
    logic        tlb;
  } ent_t;

  ent_t          mem_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic          ds_q;
  logic [OW-1:0] outst_q;
  logic [OW-1:0] outst_d;
  logic [OW-1:0] drop_q;

  logic                   accept;
  logic                   byp;
  logic                   ds_set;
  logic [FETCH_WIDTH-1:0] kept;
  logic [KW-1:0]          nkept;
  logic [KW-1:0]          pos [FETCH_WIDTH];
  ent_t                   slot [FETCH_WIDTH];
  ent_t                   head_e;
  logic [CW-1:0]          avail;
  logic [CW-1:0]          deq;
  int                     lim;

  assign accept = inst_ibus_data_ok && !flush && (drop_q == '0);
  assign deq    = flush ? '0 : CW'(deq_cnt);

`ifdef FETCHQ_BYPASS_EN
  ent_t comp [FETCH_WIDTH];

  assign byp = accept && (count_q == '0);

  // compact kept slots into issue order for the bypass path
  always_comb begin
    for (int p = 0; p < FETCH_WIDTH; p++) begin
      comp[p] = '0;
    end
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (kept[i]) begin
        comp[pos[i]] = slot[i];
      end
    end
  end
`else
  assign byp = 1'b0;
`endif

  // unpack response slots into queue entries
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot[i].instr  = tlb_ex_in ? 32'd0 : inst_ibus_data[32*i +: 32];
      slot[i].pc     = pc_line + 32'(4 * i);
      slot[i].taken  = !tlb_ex_in && pred_taken[i];
      slot[i].target = tlb_ex_in ? 32'd0 : pred_target[32*i +: 32];
      slot[i].adel   = pc_line[1:0] != 2'b00;
      slot[i].tlb    = tlb_ex_in;
    end
  end

  // trim: start slot, one delay slot after taken, single slot on tlb/ds
  always_comb begin
    kept  = '0;
    nkept = '0;
    lim   = FETCH_WIDTH;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      pos[i] = nkept;
      if (i >= int'(inst_ibus_index) && i < lim) begin
        kept[i] = 1'b1;
        nkept   = nkept + KW'(1);
        if (tlb_ex_in || ds_q) begin
          lim = i + 1;
        end else if (pred_taken[i] && (i + 2 < lim)) begin
          lim = i + 2;
        end
      end
    end
    ds_set = kept[FETCH_WIDTH-1] && pred_taken[FETCH_WIDTH-1] && !tlb_ex_in;
  end

  // present head entries, or the live response when bypassing
  always_comb begin
    avail        = count_q;
    head_e       = '0;
    out_en       = '0;
    out_instr    = '0;
    out_pc       = '0;
    out_taken    = '0;
    out_target   = '0;
    out_exc_adel = '0;
    out_exc_tlb  = '0;
`ifdef FETCHQ_BYPASS_EN
    if (byp) begin
      avail = CW'(nkept);
    end
`endif
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      head_e = mem_q[head_q + PW'(k)];
`ifdef FETCHQ_BYPASS_EN
      if (byp) begin
        head_e = (k < FETCH_WIDTH) ? comp[k % FETCH_WIDTH] : '0;
      end
`endif
      if (CW'(k) < avail) begin
        out_en[k]              = 1'b1;
        out_instr[32*k +: 32]  = head_e.instr;
        out_pc[32*k +: 32]     = head_e.pc;
        out_taken[k]           = head_e.taken;
        out_target[32*k +: 32] = head_e.target;
        out_exc_adel[k]        = head_e.adel;
        out_exc_tlb[k]         = head_e.tlb;
      end
    end
  end

  // request only while every outstanding response still fits
  always_comb begin
    ibus_allow = (int'(count_q) + int'(outst_q) * FETCH_WIDTH
                  + FETCH_WIDTH <= DEPTH)
              && (int'(outst_q) < MAX_OUTST);
  end

  // in-flight request count
  always_comb begin
    outst_d = outst_q;
    if (inst_ibus_req_fire && !inst_ibus_data_ok) begin
      outst_d = outst_q + OW'(1);
    end else if (!inst_ibus_req_fire && inst_ibus_data_ok) begin
      outst_d = outst_q - OW'(1);
    end
  end

  // queue pointers, delay-slot flag and stale-response bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ds_q    <= 1'b0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      outst_q <= outst_d;
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        ds_q    <= 1'b0;
        drop_q  <= outst_d;
      end else begin
        head_q  <= head_q + PW'(deq);
        count_q <= count_q + (accept ? CW'(nkept) : '0) - deq;
        if (accept) begin
          tail_q <= tail_q + PW'(nkept);
          ds_q   <= ds_set;
        end
        if (inst_ibus_data_ok && drop_q != '0) begin
          drop_q <= drop_q - OW'(1);
        end
      end
    end
  end

  // write surviving slots at the tail, skipping ones popped by bypass
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (accept && kept[i] && !(byp && CW'(pos[i]) < deq)) begin
        mem_q[tail_q + PW'(pos[i])] <= slot[i];
      end
    end
  end

  // decode must never pop more entries than it was shown
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (CW'(deq_cnt) <= avail);
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed and random stimulus for instr_fetch_queue
// checked against a queue-based reference model.
module tb_instr_fetch_queue;

  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam int DEPTH = 8;
  localparam int MAXO  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          req_fire = 1'b0;
  logic          data_ok = 1'b0;
  logic [32*FW-1:0] data = '0;
  logic [32*FW-1:0] ptgt = '0;
  logic [0:0]    index = '0;
  logic [31:0]   pc_line = '0;
  logic          tlb = 1'b0;
  logic [FW-1:0] ptaken = '0;
  logic [1:0]    deq = '0;
  logic          allow;
  logic [IW-1:0] en;
  logic [IW-1:0] otaken;
  logic [IW-1:0] oadel;
  logic [IW-1:0] otlb;
  logic [32*IW-1:0] oinstr;
  logic [32*IW-1:0] opc;
  logic [32*IW-1:0] otgt;

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .FETCH_WIDTH(FW),
    .ISSUE_WIDTH(IW),
    .DEPTH(DEPTH),
    .MAX_OUTST(MAXO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .inst_ibus_req_fire(req_fire),
    .inst_ibus_data_ok(data_ok),
    .inst_ibus_data(data),
    .inst_ibus_index(index),
    .pc_line(pc_line),
    .tlb_ex_in(tlb),
    .pred_taken(ptaken),
    .pred_target(ptgt),
    .ibus_allow(allow),
    .out_en(en),
    .out_instr(oinstr),
    .out_pc(opc),
    .out_taken(otaken),
    .out_target(otgt),
    .out_exc_adel(oadel),
    .out_exc_tlb(otlb),
    .deq_cnt(deq)
  );

  typedef struct {
    logic [31:0] instr, pc, target;
    logic taken, adel, tlb;
  } ment_t;

  ment_t mq[$];
  ment_t mnew[$];
  ment_t pres[$];
  int    m_outst = 0;
  int    m_drop = 0;
  bit    m_ds = 0;
  bit    m_dsn = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kept slots of the response on the inputs, from the trimming rules
  function automatic void m_compute();
    bit    k [FW];
    int    first;
    ment_t e;
    mnew.delete();
    for (int i = 0; i < FW; i++) begin
      k[i] = (i >= int'(index));
      for (int j = 0; j < i - 1; j++) begin
        if (k[j] && ptaken[j]) k[i] = 0;
      end
    end
    if (tlb || m_ds) begin
      first = -1;
      for (int i = 0; i < FW; i++) begin
        if (k[i]) begin
          if (first < 0) first = i;
          else k[i] = 0;
        end
      end
    end
    for (int i = 0; i < FW; i++) begin
      if (k[i]) begin
        e.instr  = tlb ? 32'd0 : data[32*i +: 32];
        e.pc     = pc_line + 32'(4 * i);
        e.taken  = tlb ? 1'b0 : ptaken[i];
        e.target = tlb ? 32'd0 : ptgt[32*i +: 32];
        e.adel   = pc_line[1:0] != 2'b00;
        e.tlb    = tlb;
        mnew.push_back(e);
      end
    end
    m_dsn = k[FW-1] && ptaken[FW-1] && !tlb;
  endfunction

  function automatic bit m_byp();
`ifdef FETCHQ_BYPASS_EN
    return mq.size() == 0 && m_drop == 0 && data_ok && !flush;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_allow();
    return (DEPTH - mq.size() - m_outst * FW >= FW) && (m_outst < MAXO);
  endfunction

  function automatic int m_avail();
    int n;
    m_compute();
    if (m_byp()) pres = mnew;
    else pres = mq;
    n = pres.size() < IW ? pres.size() : IW;
    return n;
  endfunction

  task automatic check_outputs();
    int n;
    n = m_avail();
    chk("allow", 32'(allow), 32'(m_allow()));
    chk("out_en", 32'(en), 32'((1 << n) - 1));
    for (int k = 0; k < n; k++) begin
      chk($sformatf("instr%0d", k), oinstr[32*k +: 32], pres[k].instr);
      chk($sformatf("pc%0d", k), opc[32*k +: 32], pres[k].pc);
      chk($sformatf("target%0d", k), otgt[32*k +: 32], pres[k].target);
      chk($sformatf("taken%0d", k), 32'(otaken[k]), 32'(pres[k].taken));
      chk($sformatf("adel%0d", k), 32'(oadel[k]), 32'(pres[k].adel));
      chk($sformatf("tlb%0d", k), 32'(otlb[k]), 32'(pres[k].tlb));
    end
  endtask

  function automatic void m_step();
    if (flush) begin
      mq.delete();
      m_ds   = 0;
      m_drop = m_outst + int'(req_fire) - int'(data_ok);
    end else begin
      if (data_ok) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          m_compute();
          foreach (mnew[i]) mq.push_back(mnew[i]);
          m_ds = m_dsn;
        end
      end
      repeat (int'(deq)) if (mq.size() > 0) void'(mq.pop_front());
    end
    m_outst += int'(req_fire) - int'(data_ok);
  endfunction

  task automatic tick();
    @(negedge clk);
    check_outputs();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush    = 1'b0;
    req_fire = 1'b0;
    data_ok  = 1'b0;
    tlb      = 1'b0;
    ptaken   = '0;
    index    = '0;
    deq      = '0;
    data     = {$urandom, $urandom};
    ptgt     = {$urandom, $urandom};
  endtask

  task automatic fire();
    idle();
    req_fire = 1'b1;
    tick();
  endtask

  task automatic resp(input logic [31:0] pc, input logic [0:0] idx,
                      input logic [FW-1:0] pt);
    idle();
    data_ok = 1'b1;
    pc_line = pc;
    index   = idx;
    ptaken  = pt;
    tick();
  endtask

  task automatic drain();
    for (int g = 0; g < 20 && mq.size() > 0; g++) begin
      idle();
      deq = 2'(mq.size() >= 2 ? 2 : mq.size());
      tick();
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_allow", 32'(allow), 32'd1);
    chk("rst_instr", oinstr[31:0], 32'd0);
    chk("rst_pc", opc[31:0], 32'd0);
    reset = 1'b1;
    idle();
    tick();

    // start slot 1 of a response
    fire();
    resp(32'h8000_0000, 1'b1, 2'b00);
    idle();
    #1;
    chk("idx1_en", 32'(en), 32'd1);
    chk("idx1_pc", opc[31:0], 32'h8000_0004);
    tick();

    // build up five entries, then reset mid-traffic
    fire();
    idle();
    req_fire = 1'b1;
    data_ok  = 1'b1;
    pc_line  = 32'h0000_1000;
    tick();
    resp(32'h0000_1008, 1'b0, 2'b00);
    fire();
    reset = 1'b0;
    idle();
    #1;
    chk("midrst_en", 32'(en), 32'd0);
    chk("midrst_allow", 32'(allow), 32'd1);
    mq.delete();
    m_outst = 0;
    m_drop  = 0;
    m_ds    = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("postrst_en", 32'(en), 32'd0);
    tick();

    // taken in slot 0 keeps both; taken in last slot arms delay slot
    fire();
    resp(32'h0000_2000, 1'b0, 2'b01);
    idle();
    #1;
    chk("tk0_en", 32'(en), 32'd3);
    tick();
    fire();
    resp(32'h0000_2008, 1'b0, 2'b10);
    fire();
    resp(32'h0000_2010, 1'b0, 2'b00);
    idle();
    deq = 2'd2;
    tick();
    idle();
    deq = 2'd2;
    tick();
    idle();
    #1;
    chk("ds_en", 32'(en), 32'd1);
    chk("ds_pc", opc[31:0], 32'h0000_2010);
    tick();
    fire();
    resp(32'h0000_3000, 1'b0, 2'b00);
    drain();

    // tlb exception keeps a single zeroed slot
    fire();
    idle();
    data_ok = 1'b1;
    tlb     = 1'b1;
    pc_line = 32'h0000_4000;
`ifdef FETCHQ_BYPASS_EN
    #1;
    chk("tlb_byp_en0", 32'(en[0]), 32'd1);
`endif
    tick();
    idle();
    #1;
    chk("tlb_en", 32'(en), 32'd1);
    chk("tlb_flag", 32'(otlb[0]), 32'd1);
    chk("tlb_instr", oinstr[31:0], 32'd0);
    tick();
    drain();

    // fill with no dequeue, then pop two
    for (int g = 0; g < 16; g++) begin
      idle();
      req_fire = m_allow();
      data_ok  = m_outst > 0;
      pc_line  = 32'h0000_5000 + 32'(8 * g);
      tick();
    end
    idle();
    #1;
    chk("full_allow", 32'(allow), 32'd0);
    chk("full_en", 32'(en), 32'd3);
    deq = 2'd2;
    tick();
    idle();
    #1;
    chk("pop_allow", 32'(allow), 32'd1);
    tick();
    drain();

    // flush with two in flight drops both responses
    fire();
    fire();
    idle();
    flush = 1'b1;
    tick();
    for (int g = 0; g < 2; g++) begin
      idle();
      data_ok = 1'b1;
      tick();
      idle();
      #1;
      chk("drop_en", 32'(en), 32'd0);
    end
    fire();
    resp(32'h0000_6000, 1'b0, 2'b00);
    idle();
    #1;
    chk("postfl_en", 32'(en), 32'd3);
    chk("postfl_pc", opc[31:0], 32'h0000_6000);
    tick();
    drain();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      flush    = ($urandom_range(0, 29) == 0);
      req_fire = m_allow() && ($urandom_range(0, 2) != 0);
      data_ok  = (m_outst > 0) && ($urandom_range(0, 2) != 0);
      index    = 1'($urandom_range(0, 1));
      ptaken   = 2'($urandom_range(0, 3));
      tlb      = ($urandom_range(0, 15) == 0);
      pc_line  = $urandom;
      if ($urandom_range(0, 7) != 0) pc_line[1:0] = 2'b00;
      deq      = 2'($urandom_range(0, m_avail()));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
